// File: rtl/timer0_pkg.sv
// rtl/timer0_pkg.sv - shared clock-select encodings and prescaler tap indices for timer0
package timer0_pkg;

  // CS02:0 clock-select encodings of TCCR0
  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_DIV1     = 3'b001,
    CS_DIV8     = 3'b010,
    CS_DIV64    = 3'b011,
    CS_DIV256   = 3'b100,
    CS_DIV1024  = 3'b101,
    CS_EXT_FALL = 3'b110,
    CS_EXT_RISE = 3'b111
  } cs_e;

  // Prescaler bit counts whose all-ones state marks the end of a /N period
  localparam int TAP_DIV8    = 3;
  localparam int TAP_DIV64   = 6;
  localparam int TAP_DIV256  = 8;
  localparam int TAP_DIV1024 = 10;

endpackage

// File: rtl/t0_edge_detect.sv
// rtl/t0_edge_detect.sv - T0 pin synchroniser with rising/falling edge detection
module t0_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysClock,
  input  logic nReset,
  input  logic t0Pin,
  output logic risingEdge,
  output logic fallingEdge
);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncOut;
  logic                   prevLevel;

  assign syncOut = syncChain[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchroniser, then keep one cycle of history
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      syncChain <= '0;
      prevLevel <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], t0Pin};
      prevLevel <= syncOut;
    end
  end

  // Edges compare the synchronised level against the previous one; both are flops
  always_comb begin
    risingEdge  = syncOut & ~prevLevel;
    fallingEdge = ~syncOut & prevLevel;
  end

endmodule

// File: rtl/timer0_prescaler.sv
// rtl/timer0_prescaler.sv - timer0 clock select: prescaler taps or external T0 edges to a count enable
module timer0_prescaler #(
  parameter int PRESCALE_WIDTH = 10,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      sysClock,
  input  logic                      nReset,
  input  logic [7:0]                TCCR_data,
  input  logic                      PSR_reset,
  input  logic                      T0_pin,
  output logic                      countTick,
  output logic                      timerRunning,
  output logic [PRESCALE_WIDTH-1:0] prescaleCount
);

  import timer0_pkg::*;

  cs_e  clockSelect;
  logic unused_tccr;
  logic t0Rise;
  logic t0Fall;
  logic tapDiv8;
  logic tapDiv64;
  logic tapDiv256;
  logic tapDiv1024;
  logic tickNext;

  // Only CS02:0 matter; the remaining TCCR0 bits belong to the control unit
  assign clockSelect = cs_e'(TCCR_data[2:0]);
  assign unused_tccr = ^TCCR_data[7:3];

  t0_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_t0_edge_detect (
    .sysClock   (sysClock),
    .nReset     (nReset),
    .t0Pin      (T0_pin),
    .risingEdge (t0Rise),
    .fallingEdge(t0Fall)
  );

  // Free-running prescaler; a PSR10 strobe realigns it to zero and wins over the increment
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      prescaleCount <= '0;
    end else if (PSR_reset) begin
      prescaleCount <= '0;
    end else begin
      prescaleCount <= prescaleCount + PRESCALE_WIDTH'(1);
    end
  end

  // A /N period ends when the low log2(N) prescaler bits are all ones
  always_comb begin
    tapDiv8    = &prescaleCount[TAP_DIV8-1:0];
    tapDiv64   = &prescaleCount[TAP_DIV64-1:0];
    tapDiv256  = &prescaleCount[TAP_DIV256-1:0];
    tapDiv1024 = &prescaleCount[TAP_DIV1024-1:0];
  end

  // Select the next count enable; a same-cycle prescaler reset swallows a prescaled tick
  always_comb begin
    tickNext = 1'b0;
    unique case (clockSelect)
      CS_STOP:     tickNext = 1'b0;
      CS_DIV1:     tickNext = 1'b1;
      CS_DIV8:     tickNext = tapDiv8 & ~PSR_reset;
      CS_DIV64:    tickNext = tapDiv64 & ~PSR_reset;
      CS_DIV256:   tickNext = tapDiv256 & ~PSR_reset;
      CS_DIV1024:  tickNext = tapDiv1024 & ~PSR_reset;
      CS_EXT_FALL: tickNext = t0Fall;
      CS_EXT_RISE: tickNext = t0Rise;
      default:     tickNext = 1'b0;
    endcase
  end

  // Register the outputs so the control unit sees a clean single-cycle enable
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      countTick    <= 1'b0;
      timerRunning <= 1'b0;
    end else begin
      countTick    <= tickNext;
      timerRunning <= (clockSelect != CS_STOP);
    end
  end

endmodule

// File: tb/tb_timer0_prescaler.sv
// tb/tb_timer0_prescaler.sv - self-checking bench for timer0_prescaler
module tb_timer0_prescaler;

  typedef struct packed {
    logic       tick;
    logic       run;
    logic [9:0] cnt;
  } exp_t;

  logic       sysClock = 1'b0;
  logic       nReset;
  logic [7:0] TCCR_data;
  logic       PSR_reset;
  logic       T0_pin;
  logic       countTick;
  logic       timerRunning;
  logic [9:0] prescaleCount;

  int   total = 0;
  int   bad = 0;
  int   tick_seen = 0;
  int   first_edge;
  int   m_cnt = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_prev = 1'b0;
  exp_t sb[$];

  always #5 sysClock = ~sysClock;

  timer0_prescaler dut (
    .sysClock     (sysClock),
    .nReset       (nReset),
    .TCCR_data    (TCCR_data),
    .PSR_reset    (PSR_reset),
    .T0_pin       (T0_pin),
    .countTick    (countTick),
    .timerRunning (timerRunning),
    .prescaleCount(prescaleCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cs(input logic [2:0] cs);
    TCCR_data = {5'b10110, cs};
  endtask

  // Predict the post-edge outputs from the inputs now applied, then compare after the edge
  task automatic cycle();
    exp_t       e;
    exp_t       got;
    logic [2:0] cs;
    int         nxt;
    cs  = TCCR_data[2:0];
    nxt = (m_cnt + 1) % 1024;
    e   = '0;
    if (!nReset) begin
      m_cnt = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0;
    end else begin
      e.run = (cs != 3'b000);
      case (cs)
        3'b000: e.tick = 1'b0;
        3'b001: e.tick = 1'b1;
        3'b010: e.tick = !PSR_reset && (nxt % 8 == 0);
        3'b011: e.tick = !PSR_reset && (nxt % 64 == 0);
        3'b100: e.tick = !PSR_reset && (nxt % 256 == 0);
        3'b101: e.tick = !PSR_reset && (nxt % 1024 == 0);
        3'b110: e.tick = !m_s2 && m_prev;
        default: e.tick = m_s2 && !m_prev;
      endcase
      e.cnt  = PSR_reset ? 10'd0 : 10'(nxt);
      m_cnt  = int'(e.cnt);
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = T0_pin;
    end
    sb.push_back(e);
    @(posedge sysClock);
    #1;
    got = sb.pop_front();
    check("countTick", 32'(countTick), 32'(got.tick));
    check("timerRunning", 32'(timerRunning), 32'(got.run));
    check("prescaleCount", 32'(prescaleCount), 32'(got.cnt));
    if (countTick === 1'b1) tick_seen++;
  endtask

  task automatic wait_first_tick(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      cycle();
      if (countTick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    nReset    = 1'b0;
    PSR_reset = 1'b0;
    T0_pin    = 1'b0;
    set_cs(3'b010);

    // Reset held for three cycles, then /8
    #2;
    check("reset_tick", 32'(countTick), 32'd0);
    check("reset_run", 32'(timerRunning), 32'd0);
    check("reset_cnt", 32'(prescaleCount), 32'd0);
    repeat (3) cycle();
    nReset = 1'b1;
    wait_first_tick(20, first_edge);
    check("div8_first_edge", 32'(first_edge), 32'd8);
    check("div8_running", 32'(timerRunning), 32'd1);
    tick_seen = 0;
    repeat (16) cycle();
    check("div8_ticks_in_16", 32'(tick_seen), 32'd2);

    // /1024 with PSR landing on the wrap
    set_cs(3'b101);
    for (int i = 0; i < 1100; i++) begin
      if (m_cnt == 1023) break;
      cycle();
    end
    check("cnt_at_1023", 32'(prescaleCount), 32'd1023);
    PSR_reset = 1'b1;
    cycle();
    check("psr_no_tick", 32'(countTick), 32'd0);
    check("psr_cnt_zero", 32'(prescaleCount), 32'd0);
    PSR_reset = 1'b0;
    wait_first_tick(1100, first_edge);
    check("div1024_first_edge", 32'(first_edge), 32'd1024);

    // External rising edges with 4-cycle phases
    set_cs(3'b111);
    T0_pin = 1'b0;
    repeat (4) cycle();
    tick_seen = 0;
    T0_pin = 1'b1;
    cycle(); check("ext_lat_e1", 32'(countTick), 32'd0);
    cycle(); check("ext_lat_e2", 32'(countTick), 32'd0);
    cycle(); check("ext_lat_e3", 32'(countTick), 32'd1);
    cycle(); check("ext_lat_e4", 32'(countTick), 32'd0);
    T0_pin = 1'b0;
    repeat (4) cycle();
    for (int p = 0; p < 2; p++) begin
      T0_pin = 1'b1; repeat (4) cycle();
      T0_pin = 1'b0; repeat (4) cycle();
    end
    check("rise_tick_count", 32'(tick_seen), 32'd3);

    // External falling edges
    set_cs(3'b110);
    tick_seen = 0;
    for (int p = 0; p < 2; p++) begin
      T0_pin = 1'b1; repeat (4) cycle();
      T0_pin = 1'b0; repeat (4) cycle();
    end
    check("fall_tick_count", 32'(tick_seen), 32'd2);

    // Mode switching: clk/1, stop, then external rise with T0 already high
    set_cs(3'b001);
    repeat (3) cycle();
    check("div1_held", 32'(countTick), 32'd1);
    set_cs(3'b000);
    cycle();
    check("stop_tick_drop", 32'(countTick), 32'd0);
    check("stop_not_running", 32'(timerRunning), 32'd0);
    T0_pin = 1'b1;
    repeat (4) cycle();
    set_cs(3'b111);
    tick_seen = 0;
    repeat (6) cycle();
    check("no_spurious_edge", 32'(tick_seen), 32'd0);

    // Asynchronous reset mid-operation in /64
    T0_pin = 1'b0;
    set_cs(3'b011);
    repeat (20) cycle();
    #2;
    nReset = 1'b0;
    #1;
    check("async_tick", 32'(countTick), 32'd0);
    check("async_run", 32'(timerRunning), 32'd0);
    check("async_cnt", 32'(prescaleCount), 32'd0);
    repeat (2) cycle();
    nReset = 1'b1;
    wait_first_tick(80, first_edge);
    check("div64_first_edge", 32'(first_edge), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
